elem_gather: RTL and testbench

Scalar-to-vector gatherer: the converse of the T-lane reduction tree. It accepts one WIDTH-bit element per handshake, typically a reduced inner-product result, and packs T consecutive elements into a T*WIDTH row. It presents the row downstream with a valid/ready handshake so the matrix datapath can write back full rows. Security-level masking is applied at capture.

---
 rtl/frodo_pkg.sv | 34 +++
 rtl/gather_bank.sv | 66 ++++++
 rtl/elem_gather.sv | 136 +++++++++++++
 tb/tb_elem_gather.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/frodo_pkg.sv
// Shared gatherer definitions: security-level codes, bank state encoding and sizing helpers.
package frodo_pkg;

   localparam logic [2:0] SEC_LEV_1 = 3'd1;
   localparam logic [2:0] SEC_LEV_3 = 3'd3;
   localparam logic [2:0] SEC_LEV_5 = 3'd5;

   typedef enum logic [1:0] {
      BANK_EMPTY   = 2'd0,
      BANK_FILLING = 2'd1,
      BANK_FULL    = 2'd2
   } bank_state_e;

   function automatic int CLOG2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r++;
      end
      return r;
   endfunction

   // Only level 1 strips the element MSB; unknown codes pass data through.
   function automatic logic sec_masks_msb(input logic [2:0] lev);
      logic m;
      case (lev)
         SEC_LEV_1:            m = 1'b1;
         SEC_LEV_3, SEC_LEV_5: m = 1'b0;
         default:              m = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/gather_bank.sv
// One row buffer of the gatherer: lane write decode with capture masking, plus its EMPTY/FILLING/FULL state.
module gather_bank
   import frodo_pkg::*;
#(
   parameter int T     = 16,
   parameter int WIDTH = 16,
   parameter int LW    = CLOG2(T)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_clear,
   input  logic               i_wr,
   input  logic [LW-1:0]      i_lane,
   input  logic               i_last,
   input  logic               i_mask,
   input  logic [WIDTH-1:0]   i_element,
   input  logic               i_drain,
   output logic               o_full,
   output logic [T*WIDTH-1:0] o_row
);

   bank_state_e        state_q, state_d;
   logic [T*WIDTH-1:0] row_q, row_d;
   logic [WIDTH-1:0]   lane_dat;

   always_comb begin
      lane_dat = i_element;
      if (i_mask) begin
         lane_dat[WIDTH-1] = 1'b0;
      end
   end

   // A clear never touches a FULL bank; a write after a clear in the same cycle wins.
   always_comb begin
      row_d   = row_q;
      state_d = state_q;
      if (i_clear && (state_q != BANK_FULL)) begin
         state_d = BANK_EMPTY;
      end
      if (i_wr) begin
         for (int k = 0; k < T; k++) begin
            if (i_lane == LW'(k)) begin
               row_d[k*WIDTH +: WIDTH] = lane_dat;
            end
         end
         state_d = i_last ? BANK_FULL : BANK_FILLING;
      end
      if (i_drain) begin
         state_d = BANK_EMPTY;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= BANK_EMPTY;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
      end
   end

   assign o_full = (state_q == BANK_FULL);
   assign o_row  = row_q;

endmodule

// File: rtl/elem_gather.sv
// Packs T scalar elements into a T*WIDTH row with valid/ready on both sides; ELEM_GATHER_DBUF_EN selects
// ping-pong banks (fill continues while a row waits), otherwise a single bank that stalls until drained.
module elem_gather
   import frodo_pkg::*;
#(
   parameter int T     = 16,
   parameter int WIDTH = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [2:0]         i_sec_lev,
   input  logic               i_start,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [WIDTH-1:0]   i_element,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [T*WIDTH-1:0] o_array,
   output logic [CLOG2(T):0]  o_count
);

   localparam int LW = CLOG2(T);
   localparam int CW = LW + 1;

   logic [CW-1:0]      count_q, count_d;
   logic               accept;
   logic               drain;
   logic               last;
   logic               mask;
   logic [LW-1:0]      lane;
   logic               wr_full;
   logic               rd_full;
   logic               full0;
   logic [T*WIDTH-1:0] row0;

`ifdef ELEM_GATHER_DBUF_EN
   logic               wr_ptr_q, wr_ptr_d;
   logic               rd_ptr_q, rd_ptr_d;
   logic               full1;
   logic [T*WIDTH-1:0] row1;

   // Fill bank FULL implies both are FULL, since the write pointer only moves on a completed row.
   assign wr_full = wr_ptr_q ? full1 : full0;
   assign rd_full = rd_ptr_q ? full1 : full0;
   assign o_array = rd_ptr_q ? row1 : row0;

   always_comb begin
      wr_ptr_d = wr_ptr_q ^ (accept & last);
      rd_ptr_d = rd_ptr_q ^ drain;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   gather_bank #(.T(T), .WIDTH(WIDTH), .LW(LW)) u_bank0 (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   (i_start & ~wr_ptr_q),
      .i_wr      (accept & ~wr_ptr_q),
      .i_lane    (lane),
      .i_last    (last),
      .i_mask    (mask),
      .i_element (i_element),
      .i_drain   (drain & ~rd_ptr_q),
      .o_full    (full0),
      .o_row     (row0)
   );

   gather_bank #(.T(T), .WIDTH(WIDTH), .LW(LW)) u_bank1 (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   (i_start & wr_ptr_q),
      .i_wr      (accept & wr_ptr_q),
      .i_lane    (lane),
      .i_last    (last),
      .i_mask    (mask),
      .i_element (i_element),
      .i_drain   (drain & rd_ptr_q),
      .o_full    (full1),
      .o_row     (row1)
   );
`else
   assign wr_full = full0;
   assign rd_full = full0;
   assign o_array = row0;

   gather_bank #(.T(T), .WIDTH(WIDTH), .LW(LW)) u_bank0 (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   (i_start),
      .i_wr      (accept),
      .i_lane    (lane),
      .i_last    (last),
      .i_mask    (mask),
      .i_element (i_element),
      .i_drain   (drain),
      .o_full    (full0),
      .o_row     (row0)
   );
`endif

   assign o_ready = ~i_rst & ~wr_full;
   assign o_valid = rd_full;
   assign accept  = i_valid & o_ready;
   assign drain   = o_valid & i_ready;
   assign mask    = sec_masks_msb(i_sec_lev);
   assign lane    = i_start ? '0 : count_q[LW-1:0];
   assign last    = (lane == LW'(T - 1));
   assign o_count = count_q;

   always_comb begin
      count_d = count_q;
      if (i_start) begin
         count_d = '0;
      end
      if (accept) begin
         count_d = last ? '0 : (CW'(lane) + CW'(1));
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_elem_gather.sv
// Bench for elem_gather (T=4, WIDTH=16): directed scenarios plus random traffic against a queue-based row model.
module tb_elem_gather;

   localparam int T = 4;
   localparam int W = 16;
`ifdef ELEM_GATHER_DBUF_EN
   localparam int NB = 2;
`else
   localparam int NB = 1;
`endif

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic [2:0]    i_sec_lev = 3'd3;
   logic          i_start = 1'b0;
   logic          i_valid = 1'b0;
   logic          o_ready;
   logic [W-1:0]  i_element = '0;
   logic          o_valid;
   logic          i_ready = 1'b0;
   logic [T*W-1:0] o_array;
   logic [2:0]    o_count;

   elem_gather #(.T(T), .WIDTH(W)) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_sec_lev (i_sec_lev),
      .i_start   (i_start),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .i_element (i_element),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_array   (o_array),
      .o_count   (o_count)
   );

   always #5 i_clk = ~i_clk;

   int          n_chk = 0;
   int          n_fail = 0;
   bit          chk_en = 1'b0;
   logic [63:0] pend[$];
   logic [15:0] part[4];
   int          cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model holds completed rows awaiting drain and the partially filled row.
   always @(posedge i_clk) begin
      #2;
      if (chk_en) begin
         chk("o_ready", 64'(o_ready), 64'(pend.size() < NB));
         chk("o_valid", 64'(o_valid), 64'(pend.size() > 0));
         chk("o_count", 64'(o_count), 64'(cnt));
         if (pend.size() > 0) begin
            chk("o_array", o_array, pend[0]);
         end
      end
   end

   task automatic drive(input logic v, input logic [15:0] e, input logic s, input logic r,
                        input logic [2:0] sec);
      bit acc;
      bit hs;
      @(negedge i_clk);
      i_valid   = v;
      i_element = e;
      i_start   = s;
      i_ready   = r;
      i_sec_lev = sec;
      acc = v && (pend.size() < NB);
      hs  = (pend.size() > 0) && r;
      if (hs) void'(pend.pop_front());
      if (s) cnt = 0;
      if (acc) begin
         part[cnt] = (sec == 3'd1) ? (e & 16'h7fff) : e;
         cnt++;
         if (cnt == T) begin
            pend.push_back({part[3], part[2], part[1], part[0]});
            cnt = 0;
         end
      end
   endtask

   task automatic after_edge();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      #1;
      chk("rst_o_ready", 64'(o_ready), 64'd0);
      chk("rst_o_valid", 64'(o_valid), 64'd0);
      chk("rst_o_count", 64'(o_count), 64'd0);
      chk("rst_o_array", o_array, 64'd0);
      @(negedge i_clk);
      i_rst  = 1'b0;
      chk_en = 1'b1;

      // Basic row, valid for exactly one cycle
      drive(1, 16'h1111, 0, 1, 3'd3);
      drive(1, 16'h2222, 0, 1, 3'd3);
      drive(1, 16'h3333, 0, 1, 3'd3);
      drive(1, 16'h4444, 0, 1, 3'd3);
      after_edge();
      chk("basic_valid", 64'(o_valid), 64'd1);
      chk("basic_row", o_array, 64'h4444_3333_2222_1111);
      drive(0, 16'h0, 0, 1, 3'd3);
      after_edge();
      chk("basic_valid_drop", 64'(o_valid), 64'd0);

      // Masking
      for (int i = 0; i < 4; i++) drive(1, 16'hffff, 0, 0, 3'd1);
      after_edge();
      chk("mask_lev1", o_array, 64'h7fff_7fff_7fff_7fff);
      drive(0, 16'h0, 0, 1, 3'd1);
      for (int i = 0; i < 4; i++) drive(1, 16'hffff, 0, 0, 3'd5);
      after_edge();
      chk("mask_lev5", o_array, 64'hffff_ffff_ffff_ffff);
      drive(0, 16'h0, 0, 1, 3'd5);

      // Backpressure
      for (int i = 1; i <= 4; i++) drive(1, 16'(i), 0, 0, 3'd3);
      after_edge();
      chk("bp_ready_after4", 64'(o_ready), 64'(NB == 2));
      if (NB == 2) begin
         for (int i = 5; i <= 8; i++) drive(1, 16'(i), 0, 0, 3'd3);
         after_edge();
         chk("bp_ready_after8", 64'(o_ready), 64'd0);
      end
      chk("bp_row1", o_array, 64'h0004_0003_0002_0001);
      drive(0, 16'h0, 0, 1, 3'd3);
      after_edge();
      if (NB == 2) chk("bp_row2", o_array, 64'h0008_0007_0006_0005);
      drive(0, 16'h0, 0, 1, 3'd3);

      // Restart discards partial row
      drive(1, 16'haaaa, 0, 0, 3'd3);
      drive(1, 16'hbbbb, 0, 0, 3'd3);
      drive(1, 16'h0001, 1, 0, 3'd3);
      after_edge();
      chk("restart_count", 64'(o_count), 64'd1);
      drive(1, 16'h0002, 0, 0, 3'd3);
      drive(1, 16'h0003, 0, 0, 3'd3);
      drive(1, 16'h0004, 0, 0, 3'd3);
      after_edge();
      chk("restart_row", o_array, 64'h0004_0003_0002_0001);
      drive(0, 16'h0, 0, 1, 3'd3);

      // Asynchronous reset mid-row
      drive(1, 16'h0002, 0, 1, 3'd3);
      drive(1, 16'h0003, 0, 1, 3'd3);
      i_valid = 1'b0;
      chk_en  = 1'b0;
      #2;
      i_rst = 1'b1;
      #1;
      chk("arst_count", 64'(o_count), 64'd0);
      chk("arst_valid", 64'(o_valid), 64'd0);
      chk("arst_array", o_array, 64'd0);
      chk("arst_ready", 64'(o_ready), 64'd0);
      pend.delete();
      cnt = 0;
      @(negedge i_clk);
      i_rst  = 1'b0;
      chk_en = 1'b1;
      drive(1, 16'h000a, 0, 0, 3'd3);
      drive(1, 16'h000b, 0, 0, 3'd3);
      drive(1, 16'h000c, 0, 0, 3'd3);
      drive(1, 16'h000d, 0, 0, 3'd3);
      after_edge();
      chk("arst_next_row", o_array, 64'h000d_000c_000b_000a);
      drive(0, 16'h0, 0, 1, 3'd3);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 31) == 0,
               $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)));
      end
      drive(0, 16'h0, 0, 0, 3'd3);
      after_edge();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
